// File: rtl/clock_set_controller.sv
// clock_set_controller
// Edit-mode sequencer for the calendar clock's time-setting datapath.
// Walks RUN -> HOUR -> MINUTE -> MONTH -> DAY -> RUN on the mode key, turns
// add-key presses into single-cycle increment requests for the field being
// edited, holds the seconds chain while a field has been changed, blinks the
// edited field and falls back to RUN after an idle timeout.
//
// Optional feature: define CLOCK_SET_AUTO_REPEAT_EN to enable add-key
// auto-repeat while key_add_level is held.
//
// Ports:
//   clock           system clock (32.768 kHz)
//   reset           synchronous active-high reset
//   tick_10ms       single-cycle pulse every 10 ms
//   key_mode_pulse  debounced mode key press (1 cycle)
//   key_add_pulse   debounced add key press (1 cycle)
//   key_add_level   debounced add key held level (auto-repeat only)
//   status          0 RUN, 1 HOUR, 2 MINUTE, 3 MONTH, 4 DAY
//   inc_hour/inc_minute/inc_month/inc_day  single-cycle increment requests
//   sec_hold        holds the seconds chain and its prescaler in clear
//   blink           display enable for the edited field (1 = show)
module clock_set_controller #(
  parameter int unsigned TICK_W        = 11,
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned BLINK_TICKS   = 25,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_RATE   = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_10ms,
  input  logic       key_mode_pulse,
  input  logic       key_add_pulse,
  input  logic       key_add_level,
  output logic [2:0] status,
  output logic       inc_hour,
  output logic       inc_minute,
  output logic       inc_month,
  output logic       inc_day,
  output logic       sec_hold,
  output logic       blink
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_HOUR   = 3'd1;
  localparam logic [2:0] ST_MINUTE = 3'd2;
  localparam logic [2:0] ST_MONTH  = 3'd3;
  localparam logic [2:0] ST_DAY    = 3'd4;

  localparam logic [TICK_W-1:0] TIMEOUT_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [TICK_W-1:0] BLINK_LAST   = TICK_W'(BLINK_TICKS - 1);

  // inc bit order: [0] hour, [1] minute, [2] month, [3] day
  logic [3:0]        inc, inc_n;
  logic [2:0]        status_n;
  logic              sec_hold_n;
  logic              blink_n;
  logic [TICK_W-1:0] to_cnt, to_cnt_n;
  logic [TICK_W-1:0] bl_cnt, bl_cnt_n;
  logic              add_fire;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam logic [TICK_W-1:0] REPEAT_LAST   = TICK_W'(REPEAT_DELAY - 1);
  // After a repeat the counter restarts REPEAT_RATE ticks short of the trigger.
  localparam logic [TICK_W-1:0] REPEAT_RELOAD = TICK_W'(REPEAT_DELAY - REPEAT_RATE);
  logic [TICK_W-1:0] rep_cnt, rep_cnt_n;
  logic              rep_fire;
`else
  logic unused_level;
  assign unused_level = key_add_level;
`endif

  assign inc_hour   = inc[0];
  assign inc_minute = inc[1];
  assign inc_month  = inc[2];
  assign inc_day    = inc[3];

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      status   <= ST_RUN;
      inc      <= '0;
      sec_hold <= 1'b0;
      blink    <= 1'b1;
      to_cnt   <= '0;
      bl_cnt   <= '0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      status   <= status_n;
      inc      <= inc_n;
      sec_hold <= sec_hold_n;
      blink    <= blink_n;
      to_cnt   <= to_cnt_n;
      bl_cnt   <= bl_cnt_n;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      rep_cnt  <= rep_cnt_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    status_n = status;
    inc_n    = '0;
    blink_n  = blink;
    to_cnt_n = to_cnt;
    bl_cnt_n = bl_cnt;
    add_fire = 1'b0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    rep_cnt_n = rep_cnt;
    rep_fire  = 1'b0;
`endif

    if (key_mode_pulse) begin
      // Mode wins over a coincident add pulse
      status_n = (status == ST_DAY) ? ST_RUN : status + 3'd1;
      to_cnt_n = '0;
      bl_cnt_n = '0;
      blink_n  = 1'b1;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      rep_cnt_n = '0;
`endif
    end else if (status == ST_RUN) begin
      to_cnt_n = '0;
      bl_cnt_n = '0;
      blink_n  = 1'b1;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      rep_cnt_n = '0;
`endif
    end else begin
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      if (!key_add_level) begin
        rep_cnt_n = '0;
      end else if (tick_10ms) begin
        if (rep_cnt == REPEAT_LAST) begin
          rep_fire  = 1'b1;
          rep_cnt_n = REPEAT_RELOAD;
        end else begin
          rep_cnt_n = rep_cnt + 1'b1;
        end
      end
      add_fire = key_add_pulse | rep_fire;
`else
      add_fire = key_add_pulse;
`endif

      if (tick_10ms) begin
        if (bl_cnt == BLINK_LAST) begin
          bl_cnt_n = '0;
          blink_n  = ~blink;
        end else begin
          bl_cnt_n = bl_cnt + 1'b1;
        end
      end

      if (add_fire) begin
        to_cnt_n = '0;
        case (status)
          ST_HOUR:   inc_n = 4'b0001;
          ST_MINUTE: inc_n = 4'b0010;
          ST_MONTH:  inc_n = 4'b0100;
          ST_DAY:    inc_n = 4'b1000;
          default:   inc_n = 4'b0000;
        endcase
      end else if (tick_10ms) begin
        if (to_cnt == TIMEOUT_LAST) begin
          // Idle timeout: leave edit mode with display and counters at rest
          status_n = ST_RUN;
          to_cnt_n = '0;
          bl_cnt_n = '0;
          blink_n  = 1'b1;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
          rep_cnt_n = '0;
`endif
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
    end

    // Seconds stay held from the first edit until edit mode is left
    sec_hold_n = (status_n == ST_RUN) ? 1'b0 : (sec_hold | add_fire);
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed self-checking bench for clock_set_controller.
module tb_clock_set_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_10ms = 1'b0;
  logic       key_mode_pulse = 1'b0;
  logic       key_add_pulse = 1'b0;
  logic       key_add_level = 1'b0;
  logic [2:0] status;
  logic       inc_hour, inc_minute, inc_month, inc_day;
  logic       sec_hold;
  logic       blink;

  int pass_cnt = 0;
  int total_cnt = 0;

  clock_set_controller dut (
    .clock          (clock),
    .reset          (reset),
    .tick_10ms      (tick_10ms),
    .key_mode_pulse (key_mode_pulse),
    .key_add_pulse  (key_add_pulse),
    .key_add_level  (key_add_level),
    .status         (status),
    .inc_hour       (inc_hour),
    .inc_minute     (inc_minute),
    .inc_month      (inc_month),
    .inc_day        (inc_day),
    .sec_hold       (sec_hold),
    .blink          (blink)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mode_press();
    key_mode_pulse = 1'b1;
    step();
    key_mode_pulse = 1'b0;
  endtask

  task automatic add_press();
    key_add_pulse = 1'b1;
    step();
    key_add_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_10ms = 1'b1;
      step();
      tick_10ms = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    total_cnt++;
    if (status !== 3'd0) $display("FAIL reset_status got=%0d exp=0", status);
    else pass_cnt++;
    total_cnt++;
    if ({inc_hour, inc_minute, inc_month, inc_day} !== 4'b0000)
      $display("FAIL reset_inc got=%b exp=0000", {inc_hour, inc_minute, inc_month, inc_day});
    else pass_cnt++;
    total_cnt++;
    if (sec_hold !== 1'b0) $display("FAIL reset_sec_hold got=%b exp=0", sec_hold);
    else pass_cnt++;
    total_cnt++;
    if (blink !== 1'b1) $display("FAIL reset_blink got=%b exp=1", blink);
    else pass_cnt++;
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_status;
    for (int i = 0; i < 5; i++) begin
      exp_status = 3'((i + 1) % 5);
      key_mode_pulse = 1'b1;
      total_cnt++;
      if (status !== 3'((i) % 5)) $display("FAIL mode_pre%0d got=%0d exp=%0d", i, status, i % 5);
      else pass_cnt++;
      step();
      key_mode_pulse = 1'b0;
      total_cnt++;
      if (status !== exp_status) $display("FAIL mode_step%0d got=%0d exp=%0d", i, status, exp_status);
      else pass_cnt++;
      idle(9);
      total_cnt++;
      if ({inc_hour, inc_minute, inc_month, inc_day, sec_hold} !== 5'b00000)
        $display("FAIL mode_quiet%0d got=%b exp=00000", i,
                 {inc_hour, inc_minute, inc_month, inc_day, sec_hold});
      else pass_cnt++;
    end
  endtask

  task automatic test_add_edit();
    mode_press();
    mode_press();
    key_add_pulse = 1'b1;
    total_cnt++;
    if (inc_minute !== 1'b0) $display("FAIL add_latency got=%b exp=0", inc_minute);
    else pass_cnt++;
    step();
    key_add_pulse = 1'b0;
    total_cnt++;
    if ({inc_hour, inc_minute, inc_month, inc_day} !== 4'b0100)
      $display("FAIL add_minute got=%b exp=0100", {inc_hour, inc_minute, inc_month, inc_day});
    else pass_cnt++;
    total_cnt++;
    if (sec_hold !== 1'b1) $display("FAIL add_sec_hold got=%b exp=1", sec_hold);
    else pass_cnt++;
    step();
    total_cnt++;
    if (inc_minute !== 1'b0) $display("FAIL add_width got=%b exp=0", inc_minute);
    else pass_cnt++;
    mode_press();
    total_cnt++;
    if ({status, sec_hold} !== {3'd3, 1'b1})
      $display("FAIL add_hold_kept got=%0d/%b exp=3/1", status, sec_hold);
    else pass_cnt++;
    ticks(999);
    total_cnt++;
    if ({status, sec_hold} !== {3'd3, 1'b1})
      $display("FAIL add_pre_timeout got=%0d/%b exp=3/1", status, sec_hold);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if ({status, sec_hold} !== {3'd0, 1'b0})
      $display("FAIL add_timeout got=%0d/%b exp=0/0", status, sec_hold);
    else pass_cnt++;
  endtask

  task automatic test_run_and_collision();
    add_press();
    total_cnt++;
    if ({status, inc_hour, inc_minute, inc_month, inc_day, sec_hold} !== 8'b000_00000)
      $display("FAIL run_add got=%b exp=00000000",
               {status, inc_hour, inc_minute, inc_month, inc_day, sec_hold});
    else pass_cnt++;
    mode_press();
    key_mode_pulse = 1'b1;
    key_add_pulse  = 1'b1;
    step();
    key_mode_pulse = 1'b0;
    key_add_pulse  = 1'b0;
    total_cnt++;
    if ({status, inc_hour, inc_minute, inc_month, inc_day, sec_hold} !== 8'b010_00000)
      $display("FAIL collide got=%b exp=01000000",
               {status, inc_hour, inc_minute, inc_month, inc_day, sec_hold});
    else pass_cnt++;
    mode_press();
    mode_press();
    mode_press();
    total_cnt++;
    if (status !== 3'd0) $display("FAIL collide_return got=%0d exp=0", status);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    mode_press();
    ticks(998);
    // Add pulse on tick 999 restarts the idle count
    tick_10ms     = 1'b1;
    key_add_pulse = 1'b1;
    step();
    tick_10ms     = 1'b0;
    key_add_pulse = 1'b0;
    total_cnt++;
    if ({status, inc_hour, sec_hold} !== {3'd1, 1'b1, 1'b1})
      $display("FAIL to_restart got=%0d/%b/%b exp=1/1/1", status, inc_hour, sec_hold);
    else pass_cnt++;
    ticks(999);
    total_cnt++;
    if (status !== 3'd1) $display("FAIL to_hold got=%0d exp=1", status);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if ({status, sec_hold, inc_hour} !== {3'd0, 1'b0, 1'b0})
      $display("FAIL to_expire got=%0d/%b/%b exp=0/0/0", status, sec_hold, inc_hour);
    else pass_cnt++;
  endtask

  task automatic test_blink();
    for (int i = 0; i < 4; i++) mode_press();
    total_cnt++;
    if ({status, blink} !== {3'd4, 1'b1}) $display("FAIL blink_start got=%0d/%b exp=4/1", status, blink);
    else pass_cnt++;
    ticks(24);
    total_cnt++;
    if (blink !== 1'b1) $display("FAIL blink_t24 got=%b exp=1", blink);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (blink !== 1'b0) $display("FAIL blink_t25 got=%b exp=0", blink);
    else pass_cnt++;
    ticks(24);
    total_cnt++;
    if (blink !== 1'b0) $display("FAIL blink_t49 got=%b exp=0", blink);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (blink !== 1'b1) $display("FAIL blink_t50 got=%b exp=1", blink);
    else pass_cnt++;
    ticks(25);
    mode_press();
    total_cnt++;
    if ({status, blink} !== {3'd0, 1'b1}) $display("FAIL blink_run got=%0d/%b exp=0/1", status, blink);
    else pass_cnt++;
    ticks(60);
    total_cnt++;
    if (blink !== 1'b1) $display("FAIL blink_run_hold got=%b exp=1", blink);
    else pass_cnt++;
  endtask

  task automatic test_repeat();
    int  pulses;
    logic exp_inc;
    mode_press();
    key_add_level = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 100; t++) begin
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      exp_inc = (t >= 50) && ((t - 50) % 10 == 0);
`else
      exp_inc = 1'b0;
`endif
      tick_10ms = 1'b1;
      step();
      tick_10ms = 1'b0;
      if (inc_hour === 1'b1) pulses++;
      total_cnt++;
      if ({inc_hour, inc_minute, inc_month, inc_day} !== {exp_inc, 3'b000})
        $display("FAIL rep_tick%0d got=%b exp=%b", t,
                 {inc_hour, inc_minute, inc_month, inc_day}, {exp_inc, 3'b000});
      else pass_cnt++;
    end
    total_cnt++;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    if (pulses != 6) $display("FAIL rep_count got=%0d exp=6", pulses);
    else pass_cnt++;
`else
    if (pulses != 0) $display("FAIL rep_count got=%0d exp=0", pulses);
    else pass_cnt++;
`endif
    key_add_level = 1'b0;
    pulses = 0;
    for (int t = 0; t < 30; t++) begin
      tick_10ms = 1'b1;
      step();
      tick_10ms = 1'b0;
      if (inc_hour === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL rep_release got=%0d exp=0", pulses);
    else pass_cnt++;
    total_cnt++;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    if (sec_hold !== 1'b1) $display("FAIL rep_sec_hold got=%b exp=1", sec_hold);
    else pass_cnt++;
`else
    if (sec_hold !== 1'b0) $display("FAIL rep_sec_hold got=%b exp=0", sec_hold);
    else pass_cnt++;
`endif
    for (int i = 0; i < 4; i++) mode_press();
    total_cnt++;
    if ({status, sec_hold} !== {3'd0, 1'b0}) $display("FAIL rep_exit got=%0d/%b exp=0/0", status, sec_hold);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_edit();
    mode_press();
    add_press();
    key_add_pulse = 1'b1;
    reset = 1'b1;
    step();
    key_add_pulse = 1'b0;
    reset = 1'b0;
    total_cnt++;
    if ({status, inc_hour, inc_minute, inc_month, inc_day, sec_hold, blink} !== 9'b000_00000_1)
      $display("FAIL reset_mid_edit got=%b exp=000000001",
               {status, inc_hour, inc_minute, inc_month, inc_day, sec_hold, blink});
    else pass_cnt++;
  endtask

  initial begin
    idle(1);
    test_reset();
    test_mode_cycle();
    test_add_edit();
    test_run_and_collision();
    test_timeout();
    test_blink();
    test_repeat();
    test_reset_mid_edit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
